// File: rtl/tl_mem_arbiter_if.sv
// Bus bundle around the two-requester memory arbiter: fetch (m0), data (m1) and the shared memory port (s).
// slave is the arbiter's view; master is the view of the requesters and memory that surround it.
interface tl_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // Handshake rules: an a-channel beat transfers at a rising edge when a_valid && a_ready, and the
  // sender holds opcode/address/data stable until then; s_d transfers when s_d_valid && s_d_ready;
  // mX_d_valid is a one-cycle pulse with no back-pressure.
  logic              m0_a_valid;
  logic              m0_a_ready;
  logic [2:0]        m0_a_opcode;
  logic [ADDR_W-1:0] m0_a_address;
  logic [DATA_W-1:0] m0_a_data;
  logic              m0_d_valid;
  logic [2:0]        m0_d_opcode;
  logic [DATA_W-1:0] m0_d_data;

  logic              m1_a_valid;
  logic              m1_a_ready;
  logic [2:0]        m1_a_opcode;
  logic [ADDR_W-1:0] m1_a_address;
  logic [DATA_W-1:0] m1_a_data;
  logic              m1_d_valid;
  logic [2:0]        m1_d_opcode;
  logic [DATA_W-1:0] m1_d_data;

  logic              s_a_valid;
  logic              s_a_ready;
  logic [2:0]        s_a_opcode;
  logic [ADDR_W-1:0] s_a_address;
  logic [DATA_W-1:0] s_a_data;
  logic              s_d_valid;
  logic              s_d_ready;
  logic [2:0]        s_d_opcode;
  logic [DATA_W-1:0] s_d_data;

  modport slave (
    input  m0_a_valid, m0_a_opcode, m0_a_address, m0_a_data,
    output m0_a_ready, m0_d_valid, m0_d_opcode, m0_d_data,
    input  m1_a_valid, m1_a_opcode, m1_a_address, m1_a_data,
    output m1_a_ready, m1_d_valid, m1_d_opcode, m1_d_data,
    output s_a_valid, s_a_opcode, s_a_address, s_a_data,
    input  s_a_ready,
    input  s_d_valid, s_d_opcode, s_d_data,
    output s_d_ready
  );

  modport master (
    output m0_a_valid, m0_a_opcode, m0_a_address, m0_a_data,
    input  m0_a_ready, m0_d_valid, m0_d_opcode, m0_d_data,
    output m1_a_valid, m1_a_opcode, m1_a_address, m1_a_data,
    input  m1_a_ready, m1_d_valid, m1_d_opcode, m1_d_data,
    input  s_a_valid, s_a_opcode, s_a_address, s_a_data,
    output s_a_ready,
    output s_d_valid, s_d_opcode, s_d_data,
    input  s_d_ready
  );
endinterface

// File: rtl/tl_mem_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port between fetch (m0) and data (m1),
// with per-requester response routing, a response timeout and a sticky error flag.
module tl_mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  tl_mem_arbiter_if.slave  bus,
  output logic             owner,
  output logic             busy,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam logic [2:0] OP_GET = 3'b100;
  localparam logic [2:0] OP_PUT = 3'b000;
  localparam logic [2:0] OP_ERR = 3'b111;
  localparam logic [8:0] TIMEOUT_V = 9'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        a_op_q, a_op_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic [2:0]        m0_d_op_q, m0_d_op_d, m1_d_op_q, m1_d_op_d;
  logic [DATA_W-1:0] m0_d_data_q, m0_d_data_d, m1_d_data_q, m1_d_data_d;

  logic              gnt_any, gnt_sel;
  logic              m0_ready, m1_ready;
  logic              rsp_load;
  logic [2:0]        rsp_op;
  logic [DATA_W-1:0] rsp_data;
  logic [8:0]        cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      a_op_q       <= '0;
      a_addr_q     <= '0;
      a_data_q     <= '0;
      m0_d_op_q    <= '0;
      m0_d_data_q  <= '0;
      m1_d_op_q    <= '0;
      m1_d_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      a_op_q       <= a_op_d;
      a_addr_q     <= a_addr_d;
      a_data_q     <= a_data_d;
      m0_d_op_q    <= m0_d_op_d;
      m0_d_data_q  <= m0_d_data_d;
      m1_d_op_q    <= m1_d_op_d;
      m1_d_data_q  <= m1_d_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    a_op_d       = a_op_q;
    a_addr_d     = a_addr_q;
    a_data_d     = a_data_q;
    m0_d_op_d    = m0_d_op_q;
    m0_d_data_d  = m0_d_data_q;
    m1_d_op_d    = m1_d_op_q;
    m1_d_data_d  = m1_d_data_q;
    gnt_any      = 1'b0;
    gnt_sel      = 1'b0;
    m0_ready     = 1'b0;
    m1_ready     = 1'b0;
    rsp_load     = 1'b0;
    rsp_op       = OP_ERR;
    rsp_data     = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.m0_a_valid && bus.m1_a_valid) begin
          gnt_any = 1'b1;
          gnt_sel = ~last_grant_q;
        end else if (bus.m0_a_valid) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b0;
        end else if (bus.m1_a_valid) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b1;
        end
        if (gnt_any) begin
          m0_ready     = ~gnt_sel;
          m1_ready     = gnt_sel;
          owner_d      = gnt_sel;
          last_grant_d = gnt_sel;
          a_op_d       = gnt_sel ? bus.m1_a_opcode  : bus.m0_a_opcode;
          a_addr_d     = gnt_sel ? bus.m1_a_address : bus.m0_a_address;
          a_data_d     = gnt_sel ? bus.m1_a_data    : bus.m0_a_data;
          // Illegal opcodes never reach memory; they are answered locally with an error beat.
          if (a_op_d == OP_GET || a_op_d == OP_PUT) begin
            state_d = S_SEND;
          end else begin
            err_d    = 1'b1;
            rsp_load = 1'b1;
            state_d  = S_RESP;
          end
        end
      end
      S_SEND: begin
        if (bus.s_a_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A real response arriving on the timeout cycle takes priority over the error.
        if (bus.s_d_valid) begin
          rsp_load = 1'b1;
          rsp_op   = bus.s_d_opcode;
          rsp_data = bus.s_d_data;
          state_d  = S_RESP;
        end else if (cnt_inc == TIMEOUT_V) begin
          err_d    = 1'b1;
          rsp_load = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Only the owner's response registers change, so the other channel keeps its last beat.
    if (rsp_load) begin
      if (owner_d) begin
        m1_d_op_d   = rsp_op;
        m1_d_data_d = rsp_data;
      end else begin
        m0_d_op_d   = rsp_op;
        m0_d_data_d = rsp_data;
      end
    end
  end

  assign bus.m0_a_ready  = m0_ready;
  assign bus.m1_a_ready  = m1_ready;
  assign bus.m0_d_valid  = (state_q == S_RESP) && !owner_q;
  assign bus.m1_d_valid  = (state_q == S_RESP) && owner_q;
  assign bus.m0_d_opcode = m0_d_op_q;
  assign bus.m0_d_data   = m0_d_data_q;
  assign bus.m1_d_opcode = m1_d_op_q;
  assign bus.m1_d_data   = m1_d_data_q;
  assign bus.s_a_valid   = (state_q == S_SEND);
  assign bus.s_a_opcode  = a_op_q;
  assign bus.s_a_address = a_addr_q;
  assign bus.s_a_data    = a_data_q;
  assign bus.s_d_ready   = (state_q == S_WAIT);

  assign owner     = owner_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
